// File: rtl/cci_test_mmio_pkg.sv
// Shared types for the CCI-P test MMIO master: a trimmed CCI-P MMIO view,
// command/response structs and the read-slot record.
package cci_test_mmio_pkg;

  localparam int MMIO_SEQ_BITS   = 9;
  localparam int MMIO_AGE_BITS   = 16;
  localparam int CCI_MMIO_ADDR_W = 16;
  localparam int CCI_CLDATA_W    = 512;

  typedef logic [CCI_MMIO_ADDR_W-1:0] t_cci_mmioAddr;
  typedef logic [MMIO_SEQ_BITS-1:0]   t_mmio_seq;
  typedef logic [MMIO_AGE_BITS-1:0]   t_mmio_age;

  typedef enum logic [1:0] {
    CCI_MMIO_LEN_4B  = 2'd0,
    CCI_MMIO_LEN_8B  = 2'd1,
    CCI_MMIO_LEN_64B = 2'd2
  } t_cci_mmio_len;

  typedef struct packed {
    t_cci_mmioAddr address;
    t_cci_mmio_len length;
    logic          rsvd;
    t_mmio_seq     tid;
  } t_cci_c0_ReqMmioHdr;

  typedef struct packed {
    t_cci_c0_ReqMmioHdr      hdr;
    logic [CCI_CLDATA_W-1:0] data;
    logic                    rspValid;
    logic                    mmioRdValid;
    logic                    mmioWrValid;
  } t_if_cci_c0_Rx;

  typedef struct packed {
    t_mmio_seq tid;
  } t_cci_c2_RspMmioHdr;

  typedef struct packed {
    t_cci_c2_RspMmioHdr hdr;
    logic               mmioRdValid;
    logic [63:0]        data;
  } t_if_cci_c2_Tx;

  typedef struct packed {
    logic          is_write;
    t_cci_mmioAddr addr;
    logic [63:0]   data;
  } t_mmio_cmd;

  typedef struct packed {
    logic [63:0]   data;
    t_cci_mmioAddr addr;
    logic          timeout;
  } t_mmio_rsp;

  typedef struct packed {
    logic          busy;
    t_mmio_seq     tid;
    t_cci_mmioAddr addr;
    t_mmio_age     age;
  } t_mmio_slot;

  // A single-slot table still needs a 1-bit index.
  function automatic int slot_idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cci_test_mmio_slot_table.sv
// Outstanding-read slot table: allocation, TID match, per-slot ageing and a
// single registered completion per cycle (hit beats timeout).
module cci_test_mmio_slot_table
  import cci_test_mmio_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 512
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc_en,
  input  t_mmio_seq     alloc_tid,
  input  t_cci_mmioAddr alloc_addr,
  output logic          alloc_free,
  input  logic          lk_valid,
  input  t_mmio_seq     lk_tid,
  input  logic [63:0]   lk_data,
  output logic          lk_miss,
  output logic          cpl_fire,
  output logic          cpl_valid,
  output t_mmio_rsp     cpl
);

  localparam int IDX_W = slot_idx_bits(MAX_OUTSTANDING);

  t_mmio_slot       slot_q [MAX_OUTSTANDING];
  t_mmio_slot       slot_d [MAX_OUTSTANDING];
  t_mmio_rsp        cpl_q, cpl_d;
  logic             cpl_valid_q;
  logic [IDX_W-1:0] alloc_idx, lk_idx, to_idx;
  logic             lk_hit, to_found;

  function automatic logic [IDX_W-1:0] slot_of(input t_mmio_seq tid);
    return IDX_W'(tid & t_mmio_seq'(MAX_OUTSTANDING - 1));
  endfunction

  assign alloc_idx  = slot_of(alloc_tid);
  assign lk_idx     = slot_of(lk_tid);
  assign alloc_free = !slot_q[alloc_idx].busy;
  // The full 9-bit TID must match, so a late reply to a recycled slot misses.
  assign lk_hit     = lk_valid && slot_q[lk_idx].busy && (slot_q[lk_idx].tid == lk_tid);
  assign lk_miss    = lk_valid && !lk_hit;

`ifdef CCI_TEST_MMIO_MASTER_TIMEOUT_EN
  localparam t_mmio_age AGE_MAX = t_mmio_age'(TIMEOUT_CYCLES);

  // Descending scan so the lowest expired slot wins.
  always_comb begin
    to_found = 1'b0;
    to_idx   = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (slot_q[i].busy && (slot_q[i].age == AGE_MAX)) begin
        to_found = 1'b1;
        to_idx   = IDX_W'(i);
      end
    end
  end
`else
  assign to_found = 1'b0;
  assign to_idx   = '0;
`endif

  always_comb begin
    slot_d   = slot_q;
    cpl_d    = '0;
    cpl_fire = 1'b0;
`ifdef CCI_TEST_MMIO_MASTER_TIMEOUT_EN
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (slot_q[i].busy && (slot_q[i].age != AGE_MAX))
        slot_d[i].age = slot_q[i].age + 1'b1;
    end
`endif
    if (lk_hit) begin
      slot_d[lk_idx].busy = 1'b0;
      cpl_fire            = 1'b1;
      cpl_d.data          = lk_data;
      cpl_d.addr          = slot_q[lk_idx].addr;
    end else if (to_found) begin
      slot_d[to_idx].busy = 1'b0;
      cpl_fire            = 1'b1;
      cpl_d.addr          = slot_q[to_idx].addr;
      cpl_d.timeout       = 1'b1;
    end
    // Allocation only targets a free slot, so it never collides with a free.
    if (alloc_en) begin
      slot_d[alloc_idx].busy = 1'b1;
      slot_d[alloc_idx].tid  = alloc_tid;
      slot_d[alloc_idx].addr = alloc_addr;
      slot_d[alloc_idx].age  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) slot_q[i] <= '0;
      cpl_q       <= '0;
      cpl_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) slot_q[i] <= slot_d[i];
      cpl_q       <= cpl_d;
      cpl_valid_q <= cpl_fire;
    end
  end

  assign cpl_valid = cpl_valid_q;
  assign cpl       = cpl_q;

endmodule

// File: rtl/cci_test_mmio_master.sv
// Host-side MMIO initiator driving CCI-P c0 MMIO requests and retiring c2 read
// responses. Define CCI_TEST_MMIO_MASTER_TIMEOUT_EN to enable read timeouts.
module cci_test_mmio_master
  import cci_test_mmio_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 512
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_is_write,
  input  t_cci_mmioAddr cmd_addr,
  input  logic [63:0]   cmd_data,
  output t_if_cci_c0_Rx mmio_rx,
  input  t_if_cci_c2_Tx mmio_rsp,
  output logic          rsp_valid,
  output logic [63:0]   rsp_data,
  output t_cci_mmioAddr rsp_addr,
  output logic          rsp_timeout,
  output logic [6:0]    outstanding,
  output logic          err_unexpected_tid,
  output logic          err_misaligned
);

  t_mmio_cmd     cmd;
  t_if_cci_c0_Rx rx_q, rx_d;
  t_mmio_seq     seq_q, seq_d;
  logic [6:0]    outstanding_q, outstanding_d;
  logic          err_tid_q, err_tid_d, err_mis_q, err_mis_d;
  logic          slot_free, cmd_fire, rd_fire, lk_miss, cpl_fire, cpl_valid;
  t_mmio_rsp     cpl;

  // Odd addresses are forced to the enclosing 64-bit CSR.
  assign cmd = '{is_write: cmd_is_write, addr: {cmd_addr[15:1], 1'b0}, data: cmd_data};

  assign cmd_ready = !reset && (cmd.is_write || slot_free);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign rd_fire   = cmd_fire && !cmd.is_write;

  cci_test_mmio_slot_table #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
  ) u_slots (
    .clk        (clk),
    .reset      (reset),
    .alloc_en   (rd_fire),
    .alloc_tid  (seq_q),
    .alloc_addr (cmd.addr),
    .alloc_free (slot_free),
    .lk_valid   (mmio_rsp.mmioRdValid),
    .lk_tid     (mmio_rsp.hdr.tid),
    .lk_data    (mmio_rsp.data),
    .lk_miss    (lk_miss),
    .cpl_fire   (cpl_fire),
    .cpl_valid  (cpl_valid),
    .cpl        (cpl)
  );

  always_comb begin
    rx_d          = '0;
    seq_d         = seq_q;
    err_mis_d     = err_mis_q;
    err_tid_d     = err_tid_q || lk_miss;
    outstanding_d = outstanding_q + 7'(rd_fire) - 7'(cpl_fire);
    if (cmd_fire) begin
      rx_d.hdr.address = cmd.addr;
      rx_d.hdr.length  = CCI_MMIO_LEN_8B;
      if (cmd_addr[0]) err_mis_d = 1'b1;
      if (cmd.is_write) begin
        rx_d.mmioWrValid = 1'b1;
        rx_d.data        = {{(CCI_CLDATA_W-64){1'b0}}, cmd.data};
      end else begin
        rx_d.mmioRdValid = 1'b1;
        rx_d.hdr.tid     = seq_q;
        seq_d            = seq_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_q          <= '0;
      seq_q         <= '0;
      outstanding_q <= '0;
      err_tid_q     <= 1'b0;
      err_mis_q     <= 1'b0;
    end else begin
      rx_q          <= rx_d;
      seq_q         <= seq_d;
      outstanding_q <= outstanding_d;
      err_tid_q     <= err_tid_d;
      err_mis_q     <= err_mis_d;
    end
  end

  assign mmio_rx            = rx_q;
  assign rsp_valid          = cpl_valid;
  assign rsp_data           = cpl.data;
  assign rsp_addr           = cpl.addr;
  assign rsp_timeout        = cpl.timeout;
  assign outstanding        = outstanding_q;
  assign err_unexpected_tid = err_tid_q;
  assign err_misaligned     = err_mis_q;

endmodule

// File: tb/tb_cci_test_mmio_master.sv
// Directed bench for cci_test_mmio_master; completions are checked against a
// queue of expected responses pushed as stimulus is driven.
module tb_cci_test_mmio_master;
  import cci_test_mmio_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_is_write;
  t_cci_mmioAddr cmd_addr;
  logic [63:0]   cmd_data;
  t_if_cci_c0_Rx mmio_rx;
  t_if_cci_c2_Tx mmio_rsp;
  logic          rsp_valid, rsp_timeout, err_unexpected_tid, err_misaligned;
  logic [63:0]   rsp_data;
  t_cci_mmioAddr rsp_addr;
  logic [6:0]    outstanding;

  int tests = 0;
  int fails = 0;
  t_mmio_rsp exp_q[$];

  cci_test_mmio_master #(.MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_write(cmd_is_write), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .mmio_rx(mmio_rx), .mmio_rsp(mmio_rsp), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_timeout(rsp_timeout),
    .outstanding(outstanding), .err_unexpected_tid(err_unexpected_tid),
    .err_misaligned(err_misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [63:0] d, input logic [15:0] a, input logic to);
    t_mmio_rsp e;
    e.data = d; e.addr = a; e.timeout = to;
    exp_q.push_back(e);
  endtask

  task automatic send_cmd(input logic w, input logic [15:0] a, input logic [63:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_is_write = w; cmd_addr = a; cmd_data = d;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_accept_bound", {63'b0, cmd_ready}, 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic respond(input logic [8:0] tid, input logic [63:0] d);
    mmio_rsp.mmioRdValid = 1'b1; mmio_rsp.hdr.tid = tid; mmio_rsp.data = d;
    tick();
    mmio_rsp = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Completion monitor / scoreboard
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", 64'd1, 64'd0);
      else begin
        t_mmio_rsp e;
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_addr", {48'b0, rsp_addr}, {48'b0, e.addr});
        chk("rsp_timeout", {63'b0, rsp_timeout}, {63'b0, e.timeout});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b1; cmd_is_write = 1'b1; cmd_addr = '0; cmd_data = '0;
    mmio_rsp = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_cmd_ready", {63'b0, cmd_ready}, 64'd0);
    chk("rst_outputs", {58'b0, rsp_valid, outstanding != 0, err_unexpected_tid,
                        err_misaligned, mmio_rx.mmioRdValid, mmio_rx.mmioWrValid}, 64'd0);
    tick();
    cmd_valid = 1'b0;
    reset = 1'b0;
    tick();

    // Write: one-cycle mmioWrValid, no completion
    send_cmd(1'b1, 16'h0040, 64'hDEAD_BEEF_0000_0001);
    chk("wr_valid", {62'b0, mmio_rx.mmioWrValid, mmio_rx.mmioRdValid}, 64'd2);
    chk("wr_addr", {48'b0, mmio_rx.hdr.address}, 64'h40);
    chk("wr_data", mmio_rx.data[63:0], 64'hDEAD_BEEF_0000_0001);
    chk("wr_len", {62'b0, mmio_rx.hdr.length}, 64'd1);
    tick();
    chk("wr_one_cycle", {63'b0, mmio_rx.mmioWrValid}, 64'd0);
    repeat (3) tick();

    // Read with response five cycles later
    send_cmd(1'b0, 16'h0010, 64'd0);
    chk("rd_valid", {63'b0, mmio_rx.mmioRdValid}, 64'd1);
    chk("rd_tid", {55'b0, mmio_rx.hdr.tid}, 64'd0);
    chk("rd_addr", {48'b0, mmio_rx.hdr.address}, 64'h10);
    chk("rd_outstanding1", {57'b0, outstanding}, 64'd1);
    repeat (4) tick();
    push(64'h1234, 16'h0010, 1'b0);
    respond(9'd0, 64'h1234);
    chk("rd_rsp_latency", {63'b0, rsp_valid}, 64'd1);
    chk("rd_outstanding0", {57'b0, outstanding}, 64'd0);

    // Misaligned read: accepted, bit 0 cleared, sticky flag
    send_cmd(1'b0, 16'h0021, 64'd0);
    chk("mis_addr", {48'b0, mmio_rx.hdr.address}, 64'h20);
    chk("mis_tid", {55'b0, mmio_rx.hdr.tid}, 64'd1);
    chk("mis_flag", {63'b0, err_misaligned}, 64'd1);
    push(64'hABCD, 16'h0020, 1'b0);
    respond(9'd1, 64'hABCD);
    tick();

    // Reset mid-operation: slot freed, seq back to 0, no completion
    send_cmd(1'b0, 16'h0060, 64'd0);
    do_reset();
    chk("mid_rst_outstanding", {57'b0, outstanding}, 64'd0);
    chk("mid_rst_errs", {62'b0, err_misaligned, err_unexpected_tid}, 64'd0);
    send_cmd(1'b0, 16'h0068, 64'd0);
    chk("mid_rst_seq", {55'b0, mmio_rx.hdr.tid}, 64'd0);
    push(64'h55, 16'h0068, 1'b0);
    respond(9'd0, 64'h55);
    tick();

    // Stall: fifth read waits for slot 0
    do_reset();
    for (int i = 0; i < 4; i++) send_cmd(1'b0, 16'(16'h0100 + 8 * i), 64'd0);
    chk("stall_outstanding4", {57'b0, outstanding}, 64'd4);
    cmd_valid = 1'b1; cmd_is_write = 1'b0; cmd_addr = 16'h0200;
    repeat (3) begin
      @(negedge clk);
      chk("stall_ready0", {63'b0, cmd_ready}, 64'd0);
    end
    tick();
    push(64'h7777, 16'h0100, 1'b0);
    mmio_rsp.mmioRdValid = 1'b1; mmio_rsp.hdr.tid = 9'd0; mmio_rsp.data = 64'h7777;
    @(negedge clk);
    chk("stall_hold", {63'b0, cmd_ready}, 64'd0);
    tick();
    mmio_rsp = '0;
    chk("stall_rsp", {63'b0, rsp_valid}, 64'd1);
    @(negedge clk);
    chk("stall_release", {63'b0, cmd_ready}, 64'd1);
    tick();
    cmd_valid = 1'b0;
    chk("stall_fifth_valid", {63'b0, mmio_rx.mmioRdValid}, 64'd1);
    chk("stall_fifth_tid", {55'b0, mmio_rx.hdr.tid}, 64'd4);
    chk("stall_fifth_addr", {48'b0, mmio_rx.hdr.address}, 64'h200);
    for (int i = 1; i < 4; i++) begin
      push(64'(i), 16'(16'h0100 + 8 * i), 1'b0);
      respond(9'(i), 64'(i));
    end
    push(64'h4, 16'h0200, 1'b0);
    respond(9'd4, 64'h4);
    tick();
    chk("stall_drained", {57'b0, outstanding}, 64'd0);

    // Out-of-order completion
    do_reset();
    send_cmd(1'b0, 16'h0300, 64'd0);
    send_cmd(1'b0, 16'h0308, 64'd0);
    send_cmd(1'b0, 16'h0310, 64'd0);
    push(64'hC2, 16'h0310, 1'b0); respond(9'd2, 64'hC2);
    push(64'hC0, 16'h0300, 1'b0); respond(9'd0, 64'hC0);
    push(64'hC1, 16'h0308, 1'b0); respond(9'd1, 64'hC1);
    tick();
    chk("ooo_no_errs", {62'b0, err_unexpected_tid, err_misaligned}, 64'd0);
    chk("ooo_outstanding", {57'b0, outstanding}, 64'd0);

    // Unmatched TID is dropped and flagged
    respond(9'h1FF, 64'h99);
    chk("miss_flag", {63'b0, err_unexpected_tid}, 64'd1);
    tick();

    // Sequence counter wrap 511 -> 0
    do_reset();
    for (int i = 0; i < 512; i++) begin
      send_cmd(1'b0, 16'(2 * i), 64'd0);
      if (mmio_rx.hdr.tid !== 9'(i)) chk("wrap_tid", {55'b0, mmio_rx.hdr.tid}, 64'(i));
      push(64'(i), 16'(2 * i), 1'b0);
      respond(9'(i), 64'(i));
    end
    send_cmd(1'b0, 16'h0400, 64'd0);
    chk("wrap_tid0", {55'b0, mmio_rx.hdr.tid}, 64'd0);
    push(64'hF0, 16'h0400, 1'b0);
    respond(9'd0, 64'hF0);
    tick();
    chk("wrap_errs", {63'b0, err_unexpected_tid}, 64'd0);

`ifdef CCI_TEST_MMIO_MASTER_TIMEOUT_EN
    // Timeout at issue+17, then a late reply counts as a miss
    do_reset();
    send_cmd(1'b0, 16'h0050, 64'd0);
    push(64'd0, 16'h0050, 1'b1);
    repeat (16) tick();
    chk("to_not_early", {63'b0, rsp_valid}, 64'd0);
    tick();
    chk("to_fire", {63'b0, rsp_valid}, 64'd1);
    chk("to_flag", {63'b0, rsp_timeout}, 64'd1);
    tick();
    chk("to_outstanding", {57'b0, outstanding}, 64'd0);
    respond(9'd0, 64'h11);
    chk("to_late_miss", {63'b0, err_unexpected_tid}, 64'd1);

    // Hit and timeout in the same cycle: hit first
    do_reset();
    send_cmd(1'b0, 16'h0070, 64'd0);
    send_cmd(1'b0, 16'h0078, 64'd0);
    repeat (15) tick();
    push(64'hB1, 16'h0078, 1'b0);
    push(64'd0, 16'h0070, 1'b1);
    respond(9'd1, 64'hB1);
    chk("col_hit", {62'b0, rsp_valid, rsp_timeout}, 64'd2);
    tick();
    chk("col_timeout", {62'b0, rsp_valid, rsp_timeout}, 64'd3);
    tick();
    chk("col_outstanding", {57'b0, outstanding}, 64'd0);
`else
    // Without timeouts a read waits indefinitely
    do_reset();
    send_cmd(1'b0, 16'h0050, 64'd0);
    repeat (40) tick();
    chk("noto_outstanding", {57'b0, outstanding}, 64'd1);
    push(64'h66, 16'h0050, 1'b0);
    respond(9'd0, 64'h66);
    chk("noto_rsp", {62'b0, rsp_valid, rsp_timeout}, 64'd2);
    tick();
`endif

    repeat (3) tick();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
